// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a pipelined ALU; results are routed back via an in-order tag FIFO.
// Define ALU_ARB_ERR_EN to add the sticky o_err protocol-error output.
module alu_arbiter #(
  parameter int INST_W = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req0_valid,
  input  logic                     i_req1_valid,
  output logic                     o_req0_ready,
  output logic                     o_req1_ready,
  input  logic [INST_W-1:0]        i_req0_inst,
  input  logic [DATA_W-1:0]        i_req0_a,
  input  logic [DATA_W-1:0]        i_req0_b,
  input  logic [INST_W-1:0]        i_req1_inst,
  input  logic [DATA_W-1:0]        i_req1_a,
  input  logic [DATA_W-1:0]        i_req1_b,
  output logic                     o_alu_valid,
  output logic [INST_W-1:0]        o_alu_inst,
  output logic [DATA_W-1:0]        o_alu_a,
  output logic [DATA_W-1:0]        o_alu_b,
  input  logic                     i_alu_busy,
  input  logic                     i_alu_out_valid,
  input  logic [DATA_W-1:0]        i_alu_data,
  output logic                     o_rsp0_valid,
  output logic                     o_rsp1_valid,
  output logic [DATA_W-1:0]        o_rsp0_data,
  output logic [DATA_W-1:0]        o_rsp1_data,
  output logic [$clog2(DEPTH):0]   o_outstanding
`ifdef ALU_ARB_ERR_EN
  ,
  output logic                     o_err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              rr_q, rr_d;  // 1: requester 1 was granted last, so requester 0 wins a tie
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0]  tag_q, tag_d;
  logic              alu_valid_q, alu_valid_d;
  logic [INST_W-1:0] alu_inst_q, alu_inst_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
  logic              permit, gnt0, gnt1, gnt, pop, head;

  always_comb begin
    permit = i_rst_n && !i_alu_busy && (cnt_q < CNT_W'(DEPTH));
    gnt0   = permit && i_req0_valid && (!i_req1_valid || rr_q);
    gnt1   = permit && i_req1_valid && (!i_req0_valid || !rr_q);
    gnt    = gnt0 || gnt1;
    // A retire against an empty FIFO has no owner and is dropped
    pop    = i_alu_out_valid && (cnt_q != '0);
    head   = tag_q[rd_q];
  end

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;

  always_comb begin
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    tag_d        = tag_q;
    alu_valid_d  = gnt;
    alu_inst_d   = alu_inst_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp0_valid_d = pop && !head;
    rsp1_valid_d = pop && head;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;

    if (gnt) begin
      rr_d        = gnt1;
      alu_inst_d  = gnt1 ? i_req1_inst : i_req0_inst;
      alu_a_d     = gnt1 ? i_req1_a    : i_req0_a;
      alu_b_d     = gnt1 ? i_req1_b    : i_req0_b;
      tag_d[wr_q] = gnt1;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_d = rd_q + PTR_W'(1);
      if (head) rsp1_data_d = i_alu_data;
      else      rsp0_data_d = i_alu_data;
    end
    case ({gnt, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_q         <= 1'b1;
      cnt_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      tag_q        <= '0;
      alu_valid_q  <= 1'b0;
      alu_inst_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      tag_q        <= tag_d;
      alu_valid_q  <= alu_valid_d;
      alu_inst_q   <= alu_inst_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign o_alu_valid   = alu_valid_q;
  assign o_alu_inst    = alu_inst_q;
  assign o_alu_a       = alu_a_q;
  assign o_alu_b       = alu_b_q;
  assign o_rsp0_valid  = rsp0_valid_q;
  assign o_rsp1_valid  = rsp1_valid_q;
  assign o_rsp0_data   = rsp0_data_q;
  assign o_rsp1_data   = rsp1_data_q;
  assign o_outstanding = cnt_q;

`ifdef ALU_ARB_ERR_EN
  logic err_q, err_d;

  // Sticky: orphan result, or an issue presented while the ALU reports busy
  always_comb begin
    err_d = err_q || (i_alu_out_valid && (cnt_q == '0)) || (alu_valid_q && i_alu_busy);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign o_err = err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Table-driven bench for alu_arbiter: per-cycle vectors give expected readies, a queue scoreboard predicts issues, tags and responses.
module tb_alu_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req0_valid, i_req1_valid;
  logic        o_req0_ready, o_req1_ready;
  logic [3:0]  i_req0_inst, i_req1_inst;
  logic [15:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic        o_alu_valid;
  logic [3:0]  o_alu_inst;
  logic [15:0] o_alu_a, o_alu_b;
  logic        i_alu_busy, i_alu_out_valid;
  logic [15:0] i_alu_data;
  logic        o_rsp0_valid, o_rsp1_valid;
  logic [15:0] o_rsp0_data, o_rsp1_data;
  logic [2:0]  o_outstanding;
`ifdef ALU_ARB_ERR_EN
  logic        o_err;
`endif

  alu_arbiter #(.INST_W(4), .DATA_W(16), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_valid(i_req0_valid), .i_req1_valid(i_req1_valid),
    .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
    .i_req0_inst(i_req0_inst), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
    .i_req1_inst(i_req1_inst), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
    .o_alu_valid(o_alu_valid), .o_alu_inst(o_alu_inst), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .i_alu_busy(i_alu_busy), .i_alu_out_valid(i_alu_out_valid), .i_alu_data(i_alu_data),
    .o_rsp0_valid(o_rsp0_valid), .o_rsp1_valid(o_rsp1_valid),
    .o_rsp0_data(o_rsp0_data), .o_rsp1_data(o_rsp1_data),
    .o_outstanding(o_outstanding)
`ifdef ALU_ARB_ERR_EN
    , .o_err(o_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic r, v0, v1, busy, ov, e0, e1;
  } vec_t;

  typedef struct {
    logic [3:0]  inst;
    logic [15:0] a, b;
  } issue_t;

  typedef struct {
    logic        tag;
    logic [15:0] data;
  } rsp_t;

  vec_t   tbl[$];
  issue_t alu_q[$];
  logic   tag_q[$];
  rsp_t   rsp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [3:0]  hold_inst;
  logic [15:0] hold_a, hold_b, hold_r0d, hold_r1d;
  int          cnt_m;
  logic        err_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void add(input logic r, v0, v1, busy, ov, e0, e1);
    vec_t v;
    v.r = r; v.v0 = v0; v.v1 = v1; v.busy = busy; v.ov = ov; v.e0 = e0; v.e1 = e1;
    tbl.push_back(v);
  endfunction

  task automatic run(input vec_t v);
    issue_t is0, is1, ia;
    rsp_t   rp;
    logic   ev, er0, er1, retired;
    logic [15:0] od;

    is0.inst = 4'($urandom()); is0.a = 16'($urandom()); is0.b = 16'($urandom());
    is1.inst = 4'($urandom()); is1.a = 16'($urandom()); is1.b = 16'($urandom());
    od = 16'($urandom());
    i_rst_n = v.r; i_req0_valid = v.v0; i_req1_valid = v.v1;
    i_alu_busy = v.busy; i_alu_out_valid = v.ov; i_alu_data = od;
    i_req0_inst = is0.inst; i_req0_a = is0.a; i_req0_b = is0.b;
    i_req1_inst = is1.inst; i_req1_a = is1.a; i_req1_b = is1.b;
    #4;

    chk("ready0", 32'(o_req0_ready), 32'(v.e0));
    chk("ready1", 32'(o_req1_ready), 32'(v.e1));

    ev = 1'b0;
    if (alu_q.size() > 0) begin
      ia = alu_q.pop_front();
      ev = 1'b1;
      hold_inst = ia.inst; hold_a = ia.a; hold_b = ia.b;
    end
    chk("alu_valid", 32'(o_alu_valid), 32'(ev));
    chk("alu_inst", 32'(o_alu_inst), 32'(hold_inst));
    chk("alu_a", 32'(o_alu_a), 32'(hold_a));
    chk("alu_b", 32'(o_alu_b), 32'(hold_b));

    er0 = 1'b0; er1 = 1'b0;
    if (rsp_q.size() > 0) begin
      rp = rsp_q.pop_front();
      if (rp.tag) begin er1 = 1'b1; hold_r1d = rp.data; end
      else        begin er0 = 1'b1; hold_r0d = rp.data; end
    end
    chk("rsp0_valid", 32'(o_rsp0_valid), 32'(er0));
    chk("rsp1_valid", 32'(o_rsp1_valid), 32'(er1));
    chk("rsp0_data", 32'(o_rsp0_data), 32'(hold_r0d));
    chk("rsp1_data", 32'(o_rsp1_data), 32'(hold_r1d));
    chk("outstanding", 32'(o_outstanding), 32'(cnt_m));
`ifdef ALU_ARB_ERR_EN
    chk("err", 32'(o_err), 32'(err_m));
`endif

    // Predict the state after the coming edge
    if (!v.r) begin
      alu_q.delete(); tag_q.delete(); rsp_q.delete();
      hold_inst = '0; hold_a = '0; hold_b = '0; hold_r0d = '0; hold_r1d = '0;
      cnt_m = 0; err_m = 1'b0;
    end else begin
      retired = 1'b0;
      if (v.ov) begin
        if (tag_q.size() > 0) begin
          rp.tag = tag_q.pop_front(); rp.data = od;
          rsp_q.push_back(rp);
          retired = 1'b1;
        end else begin
          err_m = 1'b1;
        end
      end
      if (ev && v.busy) err_m = 1'b1;
      if (v.v0 && v.e0) begin alu_q.push_back(is0); tag_q.push_back(1'b0); end
      if (v.v1 && v.e1) begin alu_q.push_back(is1); tag_q.push_back(1'b1); end
      cnt_m = cnt_m + ((v.v0 && v.e0) || (v.v1 && v.e1) ? 1 : 0) - (retired ? 1 : 0);
    end

    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic step(input logic r, v0, v1, busy, ov, e0, e1);
    vec_t v;
    v.r = r; v.v0 = v0; v.v1 = v1; v.busy = busy; v.ov = ov; v.e0 = e0; v.e1 = e1;
    run(v);
  endtask

  initial begin
    hold_inst = '0; hold_a = '0; hold_b = '0; hold_r0d = '0; hold_r1d = '0;
    cnt_m = 0; err_m = 1'b0;
    i_rst_n = 1'b0; i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    i_alu_busy = 1'b0; i_alu_out_valid = 1'b0; i_alu_data = '0;
    i_req0_inst = '0; i_req0_a = '0; i_req0_b = '0;
    i_req1_inst = '0; i_req1_a = '0; i_req1_b = '0;

    //   r  v0 v1 bsy ov  e0 e1
    // reset with both requesting, then first tie goes to req0, next to req1
    add(0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // busy holds off both for three cycles, then pointer picks req0
    add(1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // req1 streaming, result two cycles after each issue; FIFO wraps
    add(1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 0, 1, 0, 1);
    add(1, 0, 1, 0, 1, 0, 1);
    add(1, 0, 1, 0, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // fill to DEPTH, blocked while full, retire frees one slot a cycle later
    add(1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    // tags 0,1,0 with grant and retire together at count 2
    add(1, 1, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // result with nothing outstanding is dropped
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);

    @(posedge i_clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // Reset mid-flight: tags discarded, pointer restored so req0 wins the tie
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
